radio_tx_framer: RTL and testbench

Transmit-side framer for the radio chip's 6-bit parallel sample port. It accepts 24-bit I/Q sample words over a valid/ready handshake and buffers them in a small FIFO. Each sample is serialized into four 6-bit beats with a frame strobe, in the single-data-rate format that the receive deframer expects. It sits between the software-visible TX sample path and the pad/ODDR stage that drives tx_data_out/tx_frame_out.

---
 rtl/radio_tx_framer.sv | 222 ++++++++++++++++++++++
 tb/tb_radio_tx_framer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/radio_tx_framer.sv
// Sample FIFO plus 6-bit SDR beat serializer for the radio TX sample port.
// Latency: sample pushed at t into empty FIFO -> popped t+1 -> beat 0 on tx_data_o at t+2.
// Backpressure: sample_ready_o = FIFO not full; the output side never stalls (underflow inserts zeros).

// Generic synchronous FIFO, registered count, no write-through.
// Latency: an entry is readable the cycle after it is written.
// Backpressure: wr_rdy low when full (independent of a same-cycle read).
module fifo_sync #(
    parameter int Width = 24,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [Width-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [Width-1:0] rd_dat
);
    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic             push;
    logic             pop;

    // Flags come from the registered count only, so ready/valid never depend on the opposite port.
    assign wr_rdy = (count != (PtrW+1)'(Depth));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally since Depth is a power of two; simultaneous push/pop holds count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// Serializes each 24-bit I/Q sample into four 6-bit beats (I hi, Q hi, I lo, Q lo) with frame 1,1,0,0.
// Latency: two cycles from push into an empty FIFO to beat 0; one sample consumed per four cycles.
// Backpressure: sample_ready_o is FIFO-not-full; an empty FIFO mid-stream yields a zero symbol and underflow pulse.
module radio_tx_framer #(
    parameter int FifoDepth = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [23:0] sample_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic [5:0]  tx_data_o,
    output logic        tx_frame_o,
    output logic        tx_active_o,
    output logic        underflow_o,
    output logic [15:0] underflow_cnt_o,
    input  logic        clr_cnt_i
);
    typedef struct packed {
        logic [11:0] i;
        logic [11:0] q;
    } sample_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  beat_q;
    logic [1:0]  beat_d;
    sample_t     smp_q;
    sample_t     smp_d;
    logic [5:0]  data_d;
    logic        frame_d;
    logic        ufl_d;
    logic        pop;
    logic        fifo_vld;
    sample_t     fifo_dat;
    logic [23:0] fifo_raw;
    logic [15:0] ufl_cnt_q;

    assign fifo_dat = sample_t'(fifo_raw);

    fifo_sync #(
        .Width (24),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_vld (sample_valid_i),
        .wr_rdy (sample_ready_o),
        .wr_dat (sample_i),
        .rd_vld (fifo_vld),
        .rd_rdy (pop),
        .rd_dat (fifo_raw)
    );

    // Beat b of a sample: 0=I[11:6], 1=Q[11:6], 2=I[5:0], 3=Q[5:0].
    function automatic logic [5:0] beat_data(input sample_t s, input logic [1:0] b);
        logic [5:0] d;
        case (b)
            2'd0:    d = s.i[11:6];
            2'd1:    d = s.q[11:6];
            2'd2:    d = s.i[5:0];
            default: d = s.q[5:0];
        endcase
        return d;
    endfunction

    // Next-state and next-beat logic; output registers are loaded with the beat about to be shown,
    // so beat 0 of a freshly popped sample appears in the cycle right after the pop.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        smp_d   = smp_q;
        data_d  = '0;
        frame_d = 1'b0;
        ufl_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = 2'd0;
                if (en_i && fifo_vld) begin
                    pop     = 1'b1;
                    smp_d   = fifo_dat;
                    state_d = RUN;
                    data_d  = fifo_dat.i[11:6];
                    frame_d = 1'b1;
                end
            end
            RUN: begin
                if (beat_q != 2'd3) begin
                    beat_d  = beat_q + 2'd1;
                    data_d  = beat_data(smp_q, beat_q + 2'd1);
                    frame_d = (beat_q == 2'd0);
                end else begin
                    // Symbol boundary: only here may the stream stop, so symbols are never truncated.
                    beat_d = 2'd0;
                    if (en_i) begin
                        frame_d = 1'b1;
                        if (fifo_vld) begin
                            pop    = 1'b1;
                            smp_d  = fifo_dat;
                            data_d = fifo_dat.i[11:6];
                        end else begin
                            smp_d = '0;
                            ufl_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    // State, beat index, shift register and registered pad-facing outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            smp_q       <= '0;
            tx_data_o   <= '0;
            tx_frame_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            smp_q       <= smp_d;
            tx_data_o   <= data_d;
            tx_frame_o  <= frame_d;
            underflow_o <= ufl_d;
        end
    end

    assign tx_active_o = (state_q == RUN);

    // Saturating underflow counter; a clear wins over a coincident underflow pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ufl_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            ufl_cnt_q <= '0;
        end else if (underflow_o && (ufl_cnt_q != 16'hFFFF)) begin
            ufl_cnt_q <= ufl_cnt_q + 16'd1;
        end
    end

    assign underflow_cnt_o = ufl_cnt_q;
endmodule

// File: tb/tb_radio_tx_framer.sv
module tb_radio_tx_framer;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] sample;
    logic        valid;
    logic        clr;
    logic        sample_ready_o;
    logic [5:0]  tx_data_o;
    logic        tx_frame_o;
    logic        tx_active_o;
    logic        underflow_o;
    logic [15:0] underflow_cnt_o;

    int checks = 0;
    int errors = 0;

    radio_tx_framer #(.FifoDepth(DEPTH)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .en_i            (en),
        .sample_i        (sample),
        .sample_valid_i  (valid),
        .sample_ready_o  (sample_ready_o),
        .tx_data_o       (tx_data_o),
        .tx_frame_o      (tx_frame_o),
        .tx_active_o     (tx_active_o),
        .underflow_o     (underflow_o),
        .underflow_cnt_o (underflow_cnt_o),
        .clr_cnt_i       (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a queue, the rest of the current symbol as a queue of {data,frame} beats.
    logic [23:0] mq[$];
    logic [6:0]  pend[$];
    logic [5:0]  exp_data;
    logic        exp_frame;
    logic        exp_act;
    logic        exp_ufl;
    logic [15:0] exp_cnt;
    int          preset_req = 0;

    initial begin
        int          preset_ack;
        int          sz;
        logic [23:0] s;
        logic [6:0]  b;
        bit          start;
        bit          ufl_n;
        bit          shown;
        preset_ack = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                pend.delete();
                exp_data = '0; exp_frame = 0; exp_act = 0; exp_ufl = 0; exp_cnt = '0;
            end else begin
                sz = mq.size();
                start = 0; ufl_n = 0; shown = 0; s = '0;
                if (exp_act && pend.size() > 0) begin
                    b = pend.pop_front();
                    exp_data = b[6:1]; exp_frame = b[0]; shown = 1;
                end else if (en && (exp_act || sz > 0)) begin
                    start = 1;
                    if (sz > 0) s = mq.pop_front();
                    else ufl_n = 1;
                end
                if (start) begin
                    exp_data = s[23:18]; exp_frame = 1; exp_act = 1;
                    pend.push_back({s[11:6], 1'b1});
                    pend.push_back({s[17:12], 1'b0});
                    pend.push_back({s[5:0], 1'b0});
                end else if (!shown) begin
                    exp_data = '0; exp_frame = 0; exp_act = 0;
                end
                if (clr) exp_cnt = '0;
                else if (exp_ufl && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                exp_ufl = ufl_n;
                if (valid && sz < DEPTH) mq.push_back(sample);
                if (preset_req != preset_ack) begin
                    exp_cnt = 16'hFFFE;
                    preset_ack = preset_req;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("data",   32'(tx_data_o),       32'(exp_data));
            chk("frame",  32'(tx_frame_o),      32'(exp_frame));
            chk("active", 32'(tx_active_o),     32'(exp_act));
            chk("ufl",    32'(underflow_o),     32'(exp_ufl));
            chk("cnt",    32'(underflow_cnt_o), 32'(exp_cnt));
            chk("ready",  32'(sample_ready_o),  32'(mq.size() < DEPTH));
        end
    end

    task automatic wait_ufl(input string name);
        int n = 0;
        @(negedge clk);
        while (underflow_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(underflow_o), 32'd1);
    endtask

    logic [23:0] tbl [4];

    initial begin
        tbl[0] = 24'h123456; tbl[1] = 24'hFEDCBA; tbl[2] = 24'h000FFF; tbl[3] = 24'h800801;
        en = 0; valid = 0; sample = '0; clr = 0; rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_data",   32'(tx_data_o),       32'd0);
        chk("rst_frame",  32'(tx_frame_o),      32'd0);
        chk("rst_active", 32'(tx_active_o),     32'd0);
        chk("rst_ufl",    32'(underflow_o),     32'd0);
        chk("rst_cnt",    32'(underflow_cnt_o), 32'd0);
        chk("rst_ready",  32'(sample_ready_o),  32'd1);
        rst_n = 1;

        // Single sample I=0xABC Q=0x123, then underflow.
        @(negedge clk); en = 1; valid = 1; sample = 24'hABC123;
        @(negedge clk); valid = 0;
        @(negedge clk); chk("lit_b0", 32'(tx_data_o), 32'h2A); chk("lit_f0", 32'(tx_frame_o), 32'd1);
                        chk("lit_act", 32'(tx_active_o), 32'd1);
        @(negedge clk); chk("lit_b1", 32'(tx_data_o), 32'h04); chk("lit_f1", 32'(tx_frame_o), 32'd1);
        @(negedge clk); chk("lit_b2", 32'(tx_data_o), 32'h3C); chk("lit_f2", 32'(tx_frame_o), 32'd0);
        @(negedge clk); chk("lit_b3", 32'(tx_data_o), 32'h23); chk("lit_f3", 32'(tx_frame_o), 32'd0);
        @(negedge clk); chk("lit_ufl", 32'(underflow_o), 32'd1); chk("lit_zero", 32'(tx_data_o), 32'd0);
        @(negedge clk); chk("lit_cnt1", 32'(underflow_cnt_o), 32'd1);
        @(negedge clk); en = 0;
        @(negedge clk);
        @(negedge clk); chk("lit_idle", 32'(tx_active_o), 32'd0);

        // Preload four, try a fifth into the full FIFO, then stream 16 beats.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); valid = 1; sample = tbl[i];
        end
        @(negedge clk); sample = 24'h5A5A5A;
        chk("lit_full", 32'(sample_ready_o), 32'd0);
        @(negedge clk); chk("lit_full_hold", 32'(sample_ready_o), 32'd0); valid = 0;
        @(negedge clk); en = 1;
        @(negedge clk); chk("lit_ready_after_pop", 32'(sample_ready_o), 32'd1);
                        chk("lit_s0_b0", 32'(tx_data_o), 32'h04);
        repeat (13) @(negedge clk);
        en = 0;
        chk("lit_s3_b1", 32'(tx_data_o), 32'h20);
        repeat (2) @(negedge clk);
        chk("lit_s3_b3", 32'(tx_data_o), 32'h01);
        @(negedge clk); chk("lit_b2b_idle", 32'(tx_active_o), 32'd0);
                        chk("lit_b2b_noufl", 32'(underflow_cnt_o), 32'd1);

        // Disable at beat 1: the symbol still completes, remaining entries stay queued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); valid = 1; sample = 24'h111222 + 24'(i) * 24'h222222;
        end
        @(negedge clk); valid = 0; en = 1;
        @(negedge clk);
        @(negedge clk); en = 0;
        @(negedge clk); chk("lit_dis_b2", 32'(tx_data_o), 32'h11); chk("lit_dis_act", 32'(tx_active_o), 32'd1);
        @(negedge clk); chk("lit_dis_b3", 32'(tx_data_o), 32'h22);
        @(negedge clk); chk("lit_dis_idle", 32'(tx_active_o), 32'd0); chk("lit_dis_d0", 32'(tx_data_o), 32'd0);

        // Counter saturation from a preset near the top, then clear coincident with an underflow.
        @(negedge clk); #1; force dut.ufl_cnt_q = 16'hFFFE; preset_req++;
        @(negedge clk); #1; release dut.ufl_cnt_q;
        @(negedge clk); en = 1;
        wait_ufl("ufl_wait1");
        wait_ufl("ufl_wait2");
        wait_ufl("ufl_wait3");
        @(negedge clk); chk("lit_sat", 32'(underflow_cnt_o), 32'hFFFF);
        wait_ufl("ufl_wait4");
        clr = 1;
        @(negedge clk); clr = 0; chk("lit_clr", 32'(underflow_cnt_o), 32'd0);
        en = 0;
        repeat (6) @(negedge clk);

        // Asynchronous reset at beat 2 of a running symbol.
        @(negedge clk); valid = 1; sample = 24'hC3C3C3;
        @(negedge clk); sample = 24'h3C3C3C;
        @(negedge clk); valid = 0; en = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("lit_pre_rst_act", 32'(tx_active_o), 32'd1);
        #2; rst_n = 0; #1;
        chk("lit_rst_data",   32'(tx_data_o),       32'd0);
        chk("lit_rst_frame",  32'(tx_frame_o),      32'd0);
        chk("lit_rst_active", 32'(tx_active_o),     32'd0);
        chk("lit_rst_ready",  32'(sample_ready_o),  32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("lit_post_rst_act", 32'(tx_active_o), 32'd0);
        en = 0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
